// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one-cold columns, synchronises rows,
// snapshots each column, then debounces whole-scan results into a held key code.
module keypad_scanner #(
  parameter int SCAN_CYCLES    = 5000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int CNT_WIDTH      = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] keypad_value,
  output logic       key_pressed,
  output logic       key_down
);

  // state     | meaning
  // IDLE      | no key accepted, waiting for a valid single-key scan
  // PRESS_CHK | counting consecutive identical scans of candidate
  // HELD      | key accepted, waiting for an all-released scan
  // REL_CHK   | counting consecutive all-released scans
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0]        DEB_MAX   = SW'(DEBOUNCE_SCANS);
  localparam logic [CNT_WIDTH-1:0] DWELL_END = CNT_WIDTH'(SCAN_CYCLES - 1);
  // Nibble at index 4*(row*4+col) is that key's hex code
  localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

  logic [3:0]           row_m_q, row_s_q;
  logic [1:0]           col_q;
  logic [CNT_WIDTH-1:0] dwell_q;
  logic [3:0]           snap_q [4];
  logic                 eval_q;
  logic                 dwell_end;

  state_t      state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [SW-1:0] stable_q, stable_d, stable_inc;
  logic [3:0]  value_q, value_d;
  logic        pressed_q, pressed_d;
  logic        down_q, down_d;

  logic [4:0]  n_zero;
  logic [3:0]  res_code;
  logic        res_valid, res_none;

  assign dwell_end = (dwell_q == DWELL_END);

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_m_q <= 4'hF;
      row_s_q <= 4'hF;
      col_q   <= 2'd0;
      dwell_q <= '0;
      eval_q  <= 1'b0;
      for (int i = 0; i < 4; i++) snap_q[i] <= 4'hF;
    end else begin
      row_m_q <= row_in;
      row_s_q <= row_m_q;
      eval_q  <= dwell_end && (col_q == 2'd3);
      if (dwell_end) begin
        snap_q[col_q] <= row_s_q;
        dwell_q       <= '0;
        col_q         <= col_q + 2'd1;
      end else begin
        dwell_q <= dwell_q + 1'b1;
      end
    end
  end

  always_comb begin
    n_zero   = '0;
    res_code = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!snap_q[c][r]) begin
          n_zero   = n_zero + 5'd1;
          res_code = KEYMAP[6'(4 * (4 * r + c)) +: 4];
        end
      end
    end
    res_valid = (n_zero == 5'd1);
    res_none  = (n_zero == 5'd0);
  end

  assign stable_inc = stable_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    stable_d  = stable_q;
    value_d   = value_q;
    pressed_d = 1'b0;
    down_d    = down_q;
    if (eval_q) begin
      case (state_q)
        IDLE: begin
          if (res_valid) begin
            cand_d   = res_code;
            stable_d = SW'(1);
            state_d  = PRESS_CHK;
          end
        end
        PRESS_CHK: begin
          if (!res_valid) begin
            stable_d = '0;
            state_d  = IDLE;
          end else if (res_code == cand_q) begin
            if (stable_inc == DEB_MAX) begin
              value_d   = cand_q;
              pressed_d = 1'b1;
              down_d    = 1'b1;
              stable_d  = '0;
              state_d   = HELD;
            end else begin
              stable_d = stable_inc;
            end
          end else begin
            cand_d   = res_code;
            stable_d = SW'(1);
          end
        end
        HELD: begin
          if (res_none) begin
            stable_d = SW'(1);
            state_d  = REL_CHK;
          end
        end
        REL_CHK: begin
          if (res_none) begin
            if (stable_inc == DEB_MAX) begin
              down_d   = 1'b0;
              stable_d = '0;
              state_d  = IDLE;
            end else begin
              stable_d = stable_inc;
            end
          end else begin
            stable_d = '0;
            state_d  = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      stable_q  <= '0;
      value_q   <= '0;
      pressed_q <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      stable_q  <= stable_d;
      value_q   <= value_d;
      pressed_q <= pressed_d;
      down_q    <= down_d;
    end
  end

  assign col_out      = ~(4'b0001 << col_q);
  assign keypad_value = value_q;
  assign key_pressed  = pressed_q;
  assign key_down     = down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model ties pressed keys to
// col_out, and whole-scan windows are compared against hand-derived results.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] keypad_value;
  logic       key_pressed;
  logic       key_down;

  logic [15:0] mask;   // bit r*4+c set = key at row r, column c held down

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int pulses = 0;
  int last_pulse_cycle = -1;
  logic prev_kp = 1'b0;

  keypad_scanner #(
    .SCAN_CYCLES(4),
    .DEBOUNCE_SCANS(3),
    .CNT_WIDTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_in(row_in),
    .col_out(col_out),
    .keypad_value(keypad_value),
    .key_pressed(key_pressed),
    .key_down(key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  typedef struct {
    string       name;
    logic [15:0] mask;
    int          nscans;
    int          exp_pulses;
    logic [3:0]  exp_val;
    logic        exp_down;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic clk_step();
    logic [1:0] ci;
    logic [3:0] exp_col;
    @(posedge clk);
    cycle++;
    @(negedge clk);
    ci = 2'((cycle / 4) % 4);
    exp_col = ~(4'b0001 << ci);
    chk("col_out", 32'(col_out), 32'(exp_col));
    if (key_pressed) begin
      chk("kp_single", 32'(prev_kp), 32'd0);
      pulses++;
      last_pulse_cycle = cycle;
    end
    prev_kp = key_pressed;
  endtask

  task automatic scans(input logic [15:0] m, input int n);
    mask = m;
    for (int i = 0; i < n * 16; i++) clk_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_col", 32'(col_out), 32'hE);
    chk("rst_val", 32'(keypad_value), 32'h0);
    chk("rst_kp", 32'(key_pressed), 32'h0);
    chk("rst_down", 32'(key_down), 32'h0);
    reset = 1'b1;
    cycle = 0;
    prev_kp = 1'b0;
    clk_step();
  endtask

  initial begin
    int p0;
    vecs[0]  = '{"rel_2",      16'h0000,  2, 0, 4'h5, 1'b1};
    vecs[1]  = '{"rel_3",      16'h0000,  1, 0, 4'h5, 1'b0};
    vecs[2]  = '{"bnc_a2",     16'h0008,  2, 0, 4'h5, 1'b0};
    vecs[3]  = '{"bnc_gap",    16'h0000,  1, 0, 4'h5, 1'b0};
    vecs[4]  = '{"bnc_a2b",    16'h0008,  2, 0, 4'h5, 1'b0};
    vecs[5]  = '{"bnc_a3",     16'h0008,  1, 1, 4'hA, 1'b1};
    vecs[6]  = '{"rel_a",      16'h0000,  3, 0, 4'hA, 1'b0};
    vecs[7]  = '{"ambig_0d",   16'h9000,  4, 0, 4'hA, 1'b0};
    vecs[8]  = '{"hold_7",     16'h0100, 20, 1, 4'h7, 1'b1};
    vecs[9]  = '{"rel_7",      16'h0000,  3, 0, 4'h7, 1'b0};
    vecs[10] = '{"press_9",    16'h0400,  3, 1, 4'h9, 1'b1};
    vecs[11] = '{"slide_c",    16'h0800,  3, 0, 4'h9, 1'b1};
    vecs[12] = '{"rel_9",      16'h0000,  3, 0, 4'h9, 1'b0};
    vecs[13] = '{"press_c",    16'h0800,  3, 1, 4'hC, 1'b1};
    vecs[14] = '{"rel_c",      16'h0000,  3, 0, 4'hC, 1'b0};
    vecs[15] = '{"repress_c",  16'h0800,  3, 1, 4'hC, 1'b1};

    reset = 1'b0;
    mask  = 16'h0020;
    repeat (3) @(posedge clk);

    // Basic press of '5' held from before the first scan
    do_reset();
    p0 = pulses;
    scans(16'h0020, 3);
    chk("basic_pulses", 32'(pulses - p0), 32'd1);
    chk("basic_latency", 32'(last_pulse_cycle), 32'd49);
    chk("basic_val", 32'(keypad_value), 32'h5);
    chk("basic_down", 32'(key_down), 32'h1);

    for (int i = 0; i < 16; i++) begin
      p0 = pulses;
      scans(vecs[i].mask, vecs[i].nscans);
      chk({vecs[i].name, "_pulses"}, 32'(pulses - p0), 32'(vecs[i].exp_pulses));
      chk({vecs[i].name, "_val"}, 32'(keypad_value), 32'(vecs[i].exp_val));
      chk({vecs[i].name, "_down"}, 32'(key_down), 32'(vecs[i].exp_down));
    end

    // Reset after two good scans of 'B' discards the debounce progress
    scans(16'h0000, 3);
    do_reset();
    p0 = pulses;
    scans(16'h0080, 2);
    do_reset();
    scans(16'h0080, 2);
    chk("rstb_nopulse", 32'(pulses - p0), 32'd0);
    chk("rstb_val0", 32'(keypad_value), 32'h0);
    scans(16'h0080, 1);
    chk("rstb_pulse", 32'(pulses - p0), 32'd1);
    chk("rstb_latency", 32'(last_pulse_cycle), 32'd49);
    chk("rstb_val", 32'(keypad_value), 32'hB);
    chk("rstb_down", 32'(key_down), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
